// File: rtl/hypot_arbiter_seq.sv
// hypot_arbiter_seq: round-robin two-port front end for a bit-serial floor(sqrt(x^2 + y^2)) engine
// Ports: clk/rst_n (sync, active-low); reqN_valid/ready/x/y per requester;
// rsp_valid/ready/data/id result port tagged with the requester index; busy while a job is in flight.
module hypot_arbiter_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [7:0] req0_x,
  input  logic [7:0] req0_y,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [7:0] req1_x,
  input  logic [7:0] req1_y,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [8:0] rsp_data,
  output logic       rsp_id,
  output logic       busy
);
  typedef enum logic [2:0] {IDLE, SQX, SQY, ROOT, DONE} state_t;
  state_t state, state_nx;
  logic last_grant, id, gnt0, gnt1, acc, last_cnt, ge;
  logic [7:0] x, y, op;
  // bit 17 stays zero while squaring; ROOT shifts the pairs out of the top
  logic [17:0] sum;
  logic [10:0] rem, rem_sh, trial;
  logic [8:0] root;
  logic [3:0] cnt;
  always_comb begin
    gnt0 = req0_valid && (!req1_valid || last_grant);
    gnt1 = req1_valid && (!req0_valid || !last_grant);
    req0_ready = state == IDLE && gnt0;
    req1_ready = state == IDLE && gnt1;
    acc = req0_ready || req1_ready;
    last_cnt = cnt == (state == ROOT ? 4'd8 : 4'd7);
    op = state == SQX ? x : y;
    rem_sh = {rem[8:0], sum[17:16]};
    trial = {root, 2'b01};
    ge = rem_sh >= trial;
    state_nx = state;
    unique case (state)
      IDLE:    state_nx = acc ? SQX : IDLE;
      SQX:     state_nx = last_cnt ? SQY : SQX;
      SQY:     state_nx = last_cnt ? ROOT : SQY;
      ROOT:    state_nx = last_cnt ? DONE : ROOT;
      DONE:    state_nx = rsp_ready ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      last_grant <= 1'b1;
      id <= 1'b0;
      x <= '0;
      y <= '0;
      sum <= '0;
      rem <= '0;
      root <= '0;
      cnt <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (acc) begin
          x <= gnt1 ? req1_x : req0_x;
          y <= gnt1 ? req1_y : req0_y;
          id <= gnt1;
          last_grant <= gnt1;
          sum <= '0;
          cnt <= '0;
        end
        SQX, SQY: begin
          if (op[cnt[2:0]]) sum <= sum + ({10'b0, op} << cnt[2:0]);
          cnt <= last_cnt ? 4'd0 : cnt + 4'd1;
          // root/rem are cleared only on entry to ROOT so rsp_data keeps the previous result until then
          if (state == SQY && last_cnt) begin
            rem <= '0;
            root <= '0;
          end
        end
        ROOT: begin
          sum <= {sum[15:0], 2'b00};
          rem <= ge ? rem_sh - trial : rem_sh;
          root <= {root[7:0], ge};
          cnt <= cnt + 4'd1;
        end
        default: ;
      endcase
    end
  end
  assign rsp_valid = state == DONE;
  assign rsp_data = root;
  assign rsp_id = id;
  assign busy = state != IDLE;
endmodule

// File: tb/tb_hypot_arbiter_seq.sv
// tb_hypot_arbiter_seq: directed and randomized checks of hypot_arbiter_seq against a job-level model
module tb_hypot_arbiter_seq;
  logic clk = 0, rst_n = 0, rsp_ready = 0;
  logic req0_valid = 0, req1_valid = 0;
  logic [7:0] req0_x = 0, req0_y = 0, req1_x = 0, req1_y = 0;
  logic req0_ready, req1_ready, rsp_valid, rsp_id, busy;
  logic [8:0] rsp_data;

  hypot_arbiter_seq dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_x(req0_x), .req0_y(req0_y),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_x(req1_x), .req1_y(req1_y),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  task automatic check(input bit ok, input string name, input int act, input int exp);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int hyp(input int a, input int b);
    int s = a * a + b * b;
    int r = 0;
    while ((r + 1) * (r + 1) <= s) r++;
    return r;
  endfunction

  function automatic logic [7:0] rnd8();
    case ($urandom % 8)
      0: return 8'd0;
      1: return 8'd255;
      default: return 8'($urandom);
    endcase
  endfunction

  // Job-level model: one job in flight, response due 26 cycles after its accept cycle
  typedef struct {int x; int y; logic id;} job_t;
  job_t q[$];
  bit started = 0, m_work = 0, m_last = 1, m_chk_rst = 0;
  logic ev, w0, w1;
  int cyc = 0, m_t = 0, n_acc = 0, n_done = 0, n_disc = 0, wait0 = 0, wait1 = 0;

  always @(negedge clk) begin
    ev = 0;
    w0 = 0;
    w1 = 0;
    if (started) begin
      ev = m_work && (cyc - m_t >= 26);
      w0 = !m_work && req0_valid && (!req1_valid || m_last);
      w1 = !m_work && req1_valid && (!req0_valid || !m_last);
      check(busy === m_work, "busy", busy, m_work);
      check(rsp_valid === ev, "rsp_valid", rsp_valid, ev);
      check(req0_ready === w0, "req0_ready", req0_ready, w0);
      check(req1_ready === w1, "req1_ready", req1_ready, w1);
      if (m_chk_rst) begin
        check(rsp_data === 9'd0, "rst_rsp_data", rsp_data, 0);
        check(rsp_id === 1'b0, "rst_rsp_id", rsp_id, 0);
        m_chk_rst = 0;
      end
      if (ev) begin
        check(rsp_data === 9'(hyp(q[0].x, q[0].y)), "sb_rsp_data", rsp_data, hyp(q[0].x, q[0].y));
        check(rsp_id === q[0].id, "sb_rsp_id", rsp_id, q[0].id);
      end
      wait0 = (req0_valid && !w0) ? wait0 + 1 : 0;
      wait1 = (req1_valid && !w1) ? wait1 + 1 : 0;
      if (req0_valid) check(wait0 <= 150, "starve0", wait0, 150);
      if (req1_valid) check(wait1 <= 150, "starve1", wait1, 150);
    end
    if (!rst_n) begin
      if (m_work) n_disc++;
      m_work = 0;
      m_last = 1;
      q.delete();
      m_chk_rst = 1;
      started = 1;
      wait0 = 0;
      wait1 = 0;
    end else if (started) begin
      if (ev && rsp_ready) begin
        void'(q.pop_front());
        m_work = 0;
        n_done++;
      end else if (w0 || w1) begin
        q.push_back('{x: int'(w1 ? req1_x : req0_x), y: int'(w1 ? req1_y : req0_y), id: w1});
        m_work = 1;
        m_t = cyc;
        m_last = w1;
        n_acc++;
      end
    end
    cyc++;
  end

  task automatic job(input bit id, input logic [7:0] x, input logic [7:0] y, input int exp);
    int n = 0;
    bit seen = 0;
    if (id) begin req1_x = x; req1_y = y; req1_valid = 1; end
    else begin req0_x = x; req0_y = y; req0_valid = 1; end
    while (n < 100 && !seen) begin
      @(negedge clk);
      n++;
      seen = id ? req1_ready : req0_ready;
    end
    check(seen, "accept", seen, 1);
    @(posedge clk);
    #1;
    req0_valid = 0;
    req1_valid = 0;
    n = 0;
    seen = 0;
    while (n < 60 && !seen) begin
      @(negedge clk);
      n++;
      seen = rsp_valid;
    end
    check(seen && n == 26, "latency", n, 26);
    check(rsp_data === 9'(exp), "rsp_data", rsp_data, exp);
    check(rsp_id === id, "rsp_id", rsp_id, id);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    bit idle = 0;
    while (n < 200 && !idle) begin
      @(negedge clk);
      n++;
      idle = !busy;
    end
    check(idle, "drain", idle, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1 rst_n = 0;
    @(posedge clk);
    #1 rst_n = 1;
  endtask

  initial begin
    int n, g, base;
    bit seen, a0, a1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    rsp_ready = 1;
    job(0, 8'd3, 8'd4, 5);
    job(1, 8'd255, 8'd255, 360);
    job(1, 8'd0, 8'd0, 0);
    job(1, 8'd1, 8'd1, 1);
    job(1, 8'd255, 8'd0, 255);
    job(1, 8'd12, 8'd5, 13);

    // Alternating grants with both requesters continuously valid
    pulse_reset();
    req0_x = 10; req0_y = 20; req0_valid = 1;
    req1_x = 30; req1_y = 40; req1_valid = 1;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      seen = 0;
      while (n < 100 && !seen) begin
        @(negedge clk);
        n++;
        seen = req0_ready || req1_ready;
      end
      g = int'(req1_ready);
      check(seen && g == k % 2, "grant_order", g, k % 2);
      @(posedge clk);
      #1;
      if (g == 1) begin req1_x = rnd8(); req1_y = rnd8(); end
      else begin req0_x = rnd8(); req0_y = rnd8(); end
      if (k == 3) begin req0_valid = 0; req1_valid = 0; end
    end
    wait_idle();

    // Backpressure: result held for 10 cycles while both requesters wait
    rsp_ready = 0;
    req0_x = 100; req0_y = 50; req0_valid = 1;
    n = 0;
    seen = 0;
    while (n < 100 && !seen) begin
      @(negedge clk);
      n++;
      seen = req0_ready;
    end
    check(seen, "bp_accept", seen, 1);
    @(posedge clk);
    #1;
    req0_x = 7; req0_y = 7;
    req1_x = 9; req1_y = 9; req1_valid = 1;
    n = 0;
    seen = 0;
    while (n < 60 && !seen) begin
      @(negedge clk);
      n++;
      seen = rsp_valid;
    end
    check(seen && n == 26, "bp_latency", n, 26);
    repeat (10) begin
      @(negedge clk);
      check(rsp_valid === 1'b1, "bp_valid", rsp_valid, 1);
      check(rsp_data === 9'd111, "bp_data", rsp_data, 111);
      check(rsp_id === 1'b0, "bp_id", rsp_id, 0);
      check(!req0_ready && !req1_ready, "bp_readies", req0_ready | req1_ready, 0);
    end
    @(posedge clk);
    #1 rsp_ready = 1;
    @(negedge clk);
    @(negedge clk);
    check(busy === 1'b0, "bp_idle", busy, 0);
    check(req1_ready === 1'b1, "bp_rr_grant", req1_ready, 1);
    @(posedge clk);
    #1;
    req0_valid = 0;
    req1_valid = 0;
    wait_idle();

    // Reset during SQY discards the job
    req0_x = 20; req0_y = 30; req0_valid = 1;
    n = 0;
    seen = 0;
    while (n < 100 && !seen) begin
      @(negedge clk);
      n++;
      seen = req0_ready;
    end
    @(posedge clk);
    #1 req0_valid = 0;
    repeat (11) @(posedge clk);
    #1 rst_n = 0;
    @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    check(rsp_valid === 1'b0 && busy === 1'b0, "mid_rst_state", {rsp_valid, busy}, 0);
    check(rsp_data === 9'd0 && rsp_id === 1'b0, "mid_rst_data", rsp_data, 0);
    check(!req0_ready && !req1_ready, "mid_rst_ready", req0_ready | req1_ready, 0);
    repeat (40) begin
      @(negedge clk);
      check(rsp_valid === 1'b0, "mid_rst_no_rsp", rsp_valid, 0);
    end
    @(posedge clk);
    #1;
    job(1, 8'd6, 8'd8, 10);

    // Randomized soak
    base = n_done;
    n = 0;
    while (n_done - base < 2000 && n < 85000) begin
      @(negedge clk);
      a0 = req0_valid && req0_ready;
      a1 = req1_valid && req1_ready;
      @(posedge clk);
      #1;
      n++;
      if (req0_valid && !a0) begin
        if ($urandom % 64 == 0) req0_valid = 0;
      end else begin
        req0_valid = $urandom % 4 != 0;
        req0_x = rnd8();
        req0_y = rnd8();
      end
      if (req1_valid && !a1) begin
        if ($urandom % 64 == 0) req1_valid = 0;
      end else begin
        req1_valid = $urandom % 4 != 0;
        req1_x = rnd8();
        req1_y = rnd8();
      end
      rsp_ready = $urandom % 8 != 0;
    end
    check(n_done - base >= 2000, "soak_jobs", n_done - base, 2000);
    req0_valid = 0;
    req1_valid = 0;
    rsp_ready = 1;
    wait_idle();
    check(q.size() == 0, "sb_empty", q.size(), 0);
    check(n_acc == n_done + n_disc, "sb_balance", n_done + n_disc, n_acc);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/hypot_arbiter_seq.md
# hypot_arbiter_seq

Two-port arbitrated sequencer for a shared iterative hypotenuse engine: computes floor(sqrt(x² + y²)) for 8-bit operands with no multipliers. Round-robin arbitration lets two requesters share one bit-serial datapath. A fixed-length state machine sequences the datapath: shift-add squaring, then digit-by-digit integer square root. Results return on a single valid/ready response port, tagged with the requester ID.

## Interface
- No parameters; operand width fixed at 8 bits, result 9 bits.
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  reset, synchronous, active-low
- req0_valid  in  1  requester 0 has operands
- req0_ready  out  1  requester 0 operands accepted this cycle when valid
- req0_x, req0_y  in  8 each  requester 0 operands
- req1_valid, req1_ready, req1_x, req1_y  as above for requester 1
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_data  out  9  floor(sqrt(x² + y²)), range 0..360
- rsp_id  out  1  index of requester that issued the job
- busy  out  1  high whenever state ≠ IDLE

## Operation
- States: IDLE, SQX, SQY, ROOT, DONE.
- IDLE:
  - Grant is combinational from the valids and the last_grant register.
  - One valid requester: it is granted.
  - Both valid: the requester other than last_grant is granted.
  - reqN_ready = 1 only for the granted N; 0 for the other and 0 if neither is valid.
- Accept = valid && ready. On accept:
  - latch x, y and id; set last_grant = id; clear sum and counter; go to SQX.
- Requesters hold valid and operands stable until ready. Both readies are 0 outside IDLE.
- SQX, 8 cycles, counter i = 0..7: if x[i], sum += x << i. After i = 7, go to SQY.
- SQY, 8 cycles: same as SQX with y. Sum is 17 bits, max 130050, no overflow.
- ROOT, 9 cycles, operating on the 18-bit zero-extended sum, top bit-pair first:
  - rem = (rem << 2) | next_pair
  - trial = (root << 2) | 1
  - if rem ≥ trial: rem -= trial, root = (root << 1) | 1
  - else: root = root << 1
  - rem is 11 bits, root 9 bits.
  - After 9 steps, go to DONE.
- DONE:
  - rsp_valid = 1; rsp_data = root; rsp_id = latched id.
  - All three hold stable until rsp_ready.
  - On rsp_valid && rsp_ready, go to IDLE.
- Latency is fixed and data-independent; zero operands take the full length.
- rsp_data and rsp_id are unspecified when rsp_valid = 0. Implementation holds the last value.

## Timing
- Reset (rst_n = 0 at a rising edge):
  - state = IDLE, last_grant = 1 so req0 wins the first tie.
  - sum, rem, root and counter = 0.
  - rsp_valid = 0, rsp_data = 0, rsp_id = 0, busy = 0.
  - Readies follow IDLE rules in the first cycle after reset release.
- Accept in cycle T:
  - SQX occupies T+1..T+8.
  - SQY occupies T+9..T+16.
  - ROOT occupies T+17..T+25.
  - rsp_valid first high in cycle T+26.
- rsp_ready high in cycle T+26: handshake completes there; IDLE in T+27, earliest next accept in T+27.
- Minimum issue interval is 27 cycles.
- rsp_ready may be high before rsp_valid; it has no effect outside DONE.
- Backpressure: DONE holds indefinitely; no accept while in DONE.
- Reset mid-job (any state): job is discarded, no response is ever produced, and the registers return to their reset values next cycle.
- A requester that drops valid without a ready is never accepted and has no side effects.

## Test plan
- req0 (x=3, y=4), rsp_ready tied high:
  - req0_ready high in the accept cycle T.
  - rsp_valid in T+26 with rsp_data = 5, rsp_id = 0.
  - busy high T+1..T+26.
- Extremes on req1:
  - (255, 255) → 360.
  - (0, 0) → 0.
  - (1, 1) → 1.
  - (255, 0) → 255.
  - (12, 5) → 13.
  - Each has latency 26.
- Both requesters continuously valid, first after reset:
  - Grants alternate 0, 1, 0, 1.
  - rsp_id matches.
  - The losing requester's ready stays 0 while waiting.
- Backpressure: hold rsp_ready low 10 cycles after rsp_valid:
  - rsp_data and rsp_id stay stable.
  - Both readies stay 0.
  - Release → IDLE the next cycle.
- Reset mid-job: assert rst_n = 0 for one cycle during SQY:
  - All outputs are at reset values next cycle.
  - No rsp_valid appears.
  - A new req1 job, (6, 8) → 10, completes normally.
- Randomized soak, 2000 jobs: random operands, valids and rsp_ready stalls. The scoreboard checks, in order:
  - rsp_data == floor(sqrt(x² + y²)).
  - No lost or duplicated jobs.
  - No requester starves while both are valid.
